// File: rtl/demux16_collector.sv
// demux16_collector: bit-to-word collector (inverse of a 16:1 bit mux).
// Single bits are written either to an explicit position (select) or to an
// auto-incrementing position (internal pointer). Once all 16 positions have
// been written, the assembled word is offered on a valid/ready handshake.
//
// Ports:
//   clk_50     - system clock, all state changes on the rising edge
//   reset      - synchronous active-high reset
//   in         - data bit to write
//   in_valid   - write request for in
//   in_ready   - collector accepts a bit this cycle (high while collecting)
//   select     - target bit position when auto_mode=0
//   auto_mode  - 1: position from internal pointer, 0: position from select
//   out        - assembled word (partial while collecting; qualify with out_valid)
//   out_valid  - out holds a complete word
//   out_ready  - consumer accepts out
//   bit_count  - number of distinct positions written, 0..16
//   dup_error  - one-cycle pulse after a write to an already-written position
//
// Parameter:
//   CLEAR_ON_ACCEPT - 1: word cleared on accept; 0: word retained after accept
module demux16_collector #(
  parameter bit CLEAR_ON_ACCEPT = 1'b1
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  select,
  input  logic        auto_mode,
  output logic [15:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  bit_count,
  output logic        dup_error
);

  localparam logic StCollect = 1'b0;
  localparam logic StFull    = 1'b1;

  logic        state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [15:0] mask_q, mask_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        dup_q, dup_d;
  logic [3:0]  idx;

  assign idx = auto_mode ? ptr_q : select;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    dup_d   = 1'b0;

    if (state_q == StCollect) begin
      if (in_valid) begin
        word_d[idx] = in;
        if (mask_q[idx]) begin
          // Overwrite of an already-filled position: data updates, count does not.
          dup_d = 1'b1;
        end else begin
          mask_d[idx] = 1'b1;
          count_d     = count_q + 5'd1;
          if (count_q == 5'd15) begin
            state_d = StFull;
          end
        end
        if (auto_mode) begin
          ptr_d = ptr_q + 4'd1;  // wraps 15 -> 0 naturally
        end
      end
    end else begin
      // Writes are ignored while full; only the consumer accept moves us on.
      if (out_ready) begin
        state_d = StCollect;
        mask_d  = '0;
        count_d = '0;
        ptr_d   = '0;
        if (CLEAR_ON_ACCEPT) begin
          word_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= StCollect;
      word_q  <= '0;
      mask_q  <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      dup_q   <= dup_d;
    end
  end

  assign in_ready  = (state_q == StCollect);
  assign out_valid = (state_q == StFull);
  assign out       = word_q;
  assign bit_count = count_q;
  assign dup_error = dup_q;

endmodule

// File: tb/tb_demux16_collector.sv
// Testbench for demux16_collector. Two instances share all inputs: one with
// CLEAR_ON_ACCEPT=1 (a) and one with CLEAR_ON_ACCEPT=0 (b). A behavioural
// model tracks the written positions as a set and is compared every cycle.
module tb_demux16_collector;

  logic        clk_50 = 1'b0;
  logic        reset = 1'b1;
  logic        in = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  select = 4'd0;
  logic        auto_mode = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, dup_error_a;
  logic [15:0] out_a;
  logic [4:0]  bit_count_a;
  logic        in_ready_b, out_valid_b, dup_error_b;
  logic [15:0] out_b;
  logic [4:0]  bit_count_b;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  always #10 clk_50 = ~clk_50;

  demux16_collector #(.CLEAR_ON_ACCEPT(1'b1)) dut_a (
    .clk_50(clk_50), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready_a),
    .select(select), .auto_mode(auto_mode), .out(out_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .bit_count(bit_count_a), .dup_error(dup_error_a)
  );

  demux16_collector #(.CLEAR_ON_ACCEPT(1'b0)) dut_b (
    .clk_50(clk_50), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready_b),
    .select(select), .auto_mode(auto_mode), .out(out_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .bit_count(bit_count_b), .dup_error(dup_error_b)
  );

  // Model: set of written positions, two word images, pointer as an integer.
  logic [15:0] m_written = '0;
  logic [15:0] m_word_a = '0;
  logic [15:0] m_word_b = '0;
  int          m_ptr = 0;
  bit          m_dup = 1'b0;

  function automatic bit m_full();
    return $countones(m_written) == 16;
  endfunction

  always @(posedge clk_50) begin
    if (reset) begin
      m_written = '0;
      m_word_a  = '0;
      m_word_b  = '0;
      m_ptr     = 0;
      m_dup     = 1'b0;
    end else begin
      m_dup = 1'b0;
      if (m_full()) begin
        if (out_ready) begin
          m_written = '0;
          m_ptr     = 0;
          m_word_a  = '0;
        end
      end else if (in_valid) begin
        int p;
        p = auto_mode ? m_ptr : int'(select);
        if (m_written[p]) m_dup = 1'b1;
        m_written[p] = 1'b1;
        m_word_a[p]  = in;
        m_word_b[p]  = in;
        if (auto_mode) m_ptr = (m_ptr + 1) % 16;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_50) begin
    if (started) begin
      int cnt;
      cnt = $countones(m_written);
      check("a.in_ready",  32'(in_ready_a),  32'(!m_full()));
      check("a.out_valid", 32'(out_valid_a), 32'(m_full()));
      check("a.out",       32'(out_a),       32'(m_word_a));
      check("a.bit_count", 32'(bit_count_a), 32'(cnt));
      check("a.dup_error", 32'(dup_error_a), 32'(m_dup));
      check("b.in_ready",  32'(in_ready_b),  32'(!m_full()));
      check("b.out_valid", 32'(out_valid_b), 32'(m_full()));
      check("b.out",       32'(out_b),       32'(m_word_b));
      check("b.bit_count", 32'(bit_count_b), 32'(cnt));
      check("b.dup_error", 32'(dup_error_b), 32'(m_dup));
    end
  end

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic wr(input logic b, input logic am, input logic [3:0] sel);
    in_valid  = 1'b1;
    in        = b;
    auto_mode = am;
    select    = sel;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;

    // Reset
    reset = 1'b1;
    step();
    started = 1'b1;
    step();
    reset = 1'b0;
    check("rst.out", 32'(out_a), 32'h0);
    check("rst.out_valid", 32'(out_valid_a), 32'h0);
    check("rst.in_ready", 32'(in_ready_a), 32'h1);
    check("rst.bit_count", 32'(bit_count_a), 32'h0);

    // 1: auto stream of 0xA5C3, hold while full, then accept
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      wr(pat[i], 1'b1, 4'd0);
      if (i == 14) check("t1.not_yet_valid", 32'(out_valid_a), 32'h0);
    end
    check("t1.out_valid", 32'(out_valid_a), 32'h1);
    check("t1.out", 32'(out_a), 32'hA5C3);
    check("t1.bit_count", 32'(bit_count_a), 32'd16);
    check("t1.in_ready", 32'(in_ready_a), 32'h0);
    in_valid = 1'b1;
    in = 1'b0;
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    check("t1.held", 32'(out_a), 32'hA5C3);
    accept();
    check("t1.acc_valid", 32'(out_valid_a), 32'h0);
    check("t1.acc_ready", 32'(in_ready_a), 32'h1);
    check("t1.acc_count", 32'(bit_count_a), 32'h0);
    check("t1.acc_out_a", 32'(out_a), 32'h0);
    check("t1.acc_out_b", 32'(out_b), 32'hA5C3);

    // 2: manual 15..1, then one auto write must land at bit 0
    for (int s = 15; s >= 1; s--) wr(s[0], 1'b0, 4'(s));
    wr(1'b0, 1'b1, 4'd5);
    check("t2.out", 32'(out_a), 32'hAAAA);
    check("t2.out_valid", 32'(out_valid_a), 32'h1);
    accept();

    // 3: duplicate write
    wr(1'b1, 1'b0, 4'd3);
    wr(1'b0, 1'b0, 4'd3);
    check("t3.dup", 32'(dup_error_a), 32'h1);
    check("t3.count", 32'(bit_count_a), 32'h1);
    check("t3.out", 32'(out_a), 32'h0);
    step();
    check("t3.dup_clear", 32'(dup_error_a), 32'h0);
    for (int p = 0; p < 16; p++) begin
      if (p != 3) wr(1'b1, 1'b0, 4'(p));
      if (p == 14) check("t3.not_full", 32'(out_valid_a), 32'h0);
    end
    check("t3.full", 32'(out_valid_a), 32'h1);
    check("t3.word", 32'(out_a), 32'hFFF7);
    accept();

    // 4: mixed modes, then 17 auto writes with the last one ignored
    for (int i = 0; i < 8; i++) wr(1'b1, 1'b1, 4'd0);
    for (int s = 15; s >= 8; s--) wr(1'b0, 1'b0, 4'(s));
    check("t4.mixed", 32'(out_a), 32'h00FF);
    check("t4.mixed_valid", 32'(out_valid_a), 32'h1);
    accept();
    for (int i = 0; i < 16; i++) wr(1'b1, 1'b1, 4'd0);
    wr(1'b0, 1'b1, 4'd0);
    check("t4.wrap_out", 32'(out_a), 32'hFFFF);
    check("t4.wrap_dup", 32'(dup_error_a), 32'h0);
    accept();

    // 5: reset mid-word and reset while full
    for (int i = 0; i < 10; i++) wr(1'b1, 1'b1, 4'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5.count", 32'(bit_count_a), 32'h0);
    check("t5.out", 32'(out_b), 32'h0);
    check("t5.valid", 32'(out_valid_a), 32'h0);
    for (int i = 0; i < 16; i++) wr(1'b1, 1'b1, 4'd0);
    check("t5.fresh", 32'(out_a), 32'hFFFF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5.full_rst", 32'(out_valid_a), 32'h0);

    // 6: retained word when CLEAR_ON_ACCEPT=0
    pat = 16'h1234;
    for (int i = 0; i < 16; i++) wr(pat[i], 1'b1, 4'd0);
    accept();
    check("t6.kept", 32'(out_b), 32'h1234);
    check("t6.kept_valid", 32'(out_valid_b), 32'h0);
    wr(1'b1, 1'b1, 4'd0);
    check("t6.out_b", 32'(out_b), 32'h1235);
    check("t6.count_b", 32'(bit_count_b), 32'h1);
    check("t6.out_a", 32'(out_a), 32'h0001);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux16_collector.md
Name: demux16_collector

Overview:
Bit-to-word collector, the inverse of the 16:1 bit mux. It accepts single bits, each steered either to an explicit 4-bit position or to an auto-incrementing position. It assembles a 16-bit word and presents it on a valid/ready output handshake once every position has been written. It sits between serial/bit-addressed sources and 16-bit datapath consumers.

Parameters:
CLEAR_ON_ACCEPT, 1, 1: word register cleared to 0 when the output is accepted; 0: word retained (only mask/count cleared).

Ports:
clk_50  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk_50
in  input  1  data bit to write
in_valid  input  1  write request for in
in_ready  output  1  collector can accept a bit this cycle
select  input  4  target bit position when auto_mode=0
auto_mode  input  1  1: position from internal pointer; 0: position from select
out  output  16  assembled word
out_valid  output  1  out holds a complete word
out_ready  input  1  consumer accepts out
bit_count  output  5  number of distinct positions written, 0..16
dup_error  output  1  one-cycle pulse: a write hit an already-written position

Behaviour:
- Internal state: word[15:0], mask[15:0] (written flags), count[4:0], ptr[3:0], state {COLLECT, FULL}, dup_error reg.
- Reset (synchronous, active-high): state=COLLECT, word=0, mask=0, count=0, ptr=0, dup_error=0. After reset: out=0, out_valid=0, in_ready=1, bit_count=0. Reset mid-word or in FULL discards all data; no out_valid is produced for the discarded word.
- in_ready = (state==COLLECT); out_valid = (state==FULL); out = word; bit_count = count. All are direct from registers/state, with no combinational path from inputs.
- Accepted write = in_valid && in_ready at a rising edge. idx = auto_mode ? ptr : select.
- On an accepted write:
  - word[idx] <= in.
  - If mask[idx]==0: mask[idx] <= 1 and count <= count+1.
  - If mask[idx]==1: the bit is overwritten, count is unchanged, and dup_error <= 1 for exactly the next cycle.
  - dup_error <= 0 on every cycle without a duplicate write.
- ptr advances (mod 16, 15->0 wraps) only on accepted writes with auto_mode=1. Writes with auto_mode=0 leave ptr untouched. auto_mode may change between writes without restriction.
- COLLECT -> FULL: on the edge of the accepted write that makes count 16. out_valid is high starting the cycle after the final bit (1-cycle latency). in_ready is low in that same cycle.
- FULL:
  - in_valid is ignored, with no state change and no dup_error.
  - out is held stable while out_valid=1 and out_ready=0.
- FULL -> COLLECT: on an edge where out_ready=1.
  - mask=0, count=0, ptr=0.
  - word=0 if CLEAR_ON_ACCEPT=1; otherwise word is retained.
  - in_ready=1 the following cycle. There is no same-cycle accept-and-write; in_valid in the handoff cycle is ignored since in_ready=0.
- In COLLECT, out shows the partially assembled word. Consumers must qualify it with out_valid.
- out_ready while in COLLECT has no effect.

Test Plan:
1. Reset, auto_mode=1, stream 16 accepted bits forming 0xA5C3 (bit0 first) with out_ready=0 -> out_valid rises the cycle after the 16th write, out=16'hA5C3, bit_count=16, in_ready=0. Hold 5 cycles with in_valid=1 -> out unchanged. Raise out_ready -> next cycle out_valid=0, in_ready=1, bit_count=0, out=0.
2. auto_mode=0, write positions 15 down to 0 with in=select[0] -> final out=16'hAAAA. ptr remains 0, verified by switching to auto_mode=1 and the next write landing at bit 0.
3. Duplicate: auto_mode=0, write select=3 in=1, then select=3 in=0 -> dup_error=1 for exactly one cycle after the second write, bit_count stays 1, word[3]=0. The word completes only after 15 further distinct positions.
4. Mixed modes and wrap: write bits 0..7 in auto mode, then select=15..8 manually -> completes with 16 writes and no dup_error. Alternatively, 17 auto writes with no accept -> ptr wraps and the 17th is ignored because the state is FULL.
5. Reset mid-operation: after 10 writes assert reset 1 cycle -> bit_count=0, out=0, out_valid=0. A full fresh word of 0xFFFF then completes normally. Reset asserted in FULL -> out_valid=0 on the next cycle.
6. CLEAR_ON_ACCEPT=0: complete 0x1234, accept -> out still 16'h1234 with out_valid=0. Next write to bit 0 with in=1 -> out=16'h1235, bit_count=1.
